// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register responder.
// Holds command codes, FSM/transfer enums and the read-only ID bytes.
package spi_reg_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    // Number of leading bytes that hold the device ID when read-only.
    localparam int ID_BYTES = 4;

    localparam logic [7:0] ID_BYTE0 = 8'hAD;
    localparam logic [7:0] ID_BYTE1 = 8'h1D;
    localparam logic [7:0] ID_BYTE2 = 8'hF2;
    localparam logic [7:0] ID_BYTE3 = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA
    } spi_state_t;

    typedef enum logic [1:0] {
        XF_NONE,
        XF_WRITE,
        XF_READ
    } xfer_t;

    function automatic logic [7:0] id_byte(input logic [1:0] idx);
        logic [7:0] val;
        case (idx)
            2'd0:    val = ID_BYTE0;
            2'd1:    val = ID_BYTE1;
            2'd2:    val = ID_BYTE2;
            default: val = ID_BYTE3;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit synchronizer: DEPTH-flop chain with a selectable reset value.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized).
module sync_bit #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {DEPTH{RST_VAL}};
        end else begin
            ff <= {ff[DEPTH-2:0], d};
        end
    end

    assign q = ff[DEPTH-1];

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 register responder over a 2^ADDR_W byte register file.
// Ports: clk/rst_n; sclk, cs_n, mosi (async SPI in); miso, miso_oe;
//   lcl_addr/lcl_wdata/lcl_we/lcl_rdata (SoC side);
//   spi_wr_stb/spi_wr_addr (pulse per byte written over SPI).
// Macro READONLY_ID_EN: bytes 0..3 become fixed read-only ID bytes.
module spi_reg_responder
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [ADDR_W-1:0] lcl_addr,
    input  logic [7:0]        lcl_wdata,
    input  logic              lcl_we,
    output logic [7:0]        lcl_rdata,
    output logic              spi_wr_stb,
    output logic [ADDR_W-1:0] spi_wr_addr
);

    localparam int MEM_SIZE = 1 << ADDR_W;

`ifdef READONLY_ID_EN
    localparam bit RO_EN = 1'b1;
`else
    localparam bit RO_EN = 1'b0;
`endif

    logic              sclk_s;
    logic              cs_n_s;
    logic              mosi_s;
    logic              sclk_d;
    logic              rise;
    logic              fall;

    spi_state_t        state;
    spi_state_t        state_nxt;
    xfer_t             mode;

    logic [2:0]        bit_cnt;
    logic [6:0]        shift_in;
    logic [7:0]        byte_in;
    logic              byte_done;
    logic              cmd_ok;
    logic [7:0]        shift_out;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_inc;
    logic              wr_pend;
    logic [7:0]        wr_byte;

    logic [7:0]        mem [MEM_SIZE];

    sync_bit #(
        .DEPTH   (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sclk),
        .q     (sclk_s)
    );

    sync_bit #(
        .DEPTH   (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync_cs_n (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cs_n),
        .q     (cs_n_s)
    );

    sync_bit #(
        .DEPTH   (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (mosi),
        .q     (mosi_s)
    );

    function automatic logic is_ro(input logic [ADDR_W-1:0] a);
        return RO_EN && (a < ADDR_W'(ID_BYTES));
    endfunction

    function automatic logic [7:0] rd_byte(input logic [ADDR_W-1:0] a);
        return is_ro(a) ? id_byte(a[1:0]) : mem[a];
    endfunction

    assign rise      = sclk_s & ~sclk_d;
    assign fall      = ~sclk_s & sclk_d;
    assign byte_in   = {shift_in, mosi_s};
    assign byte_done = rise && (bit_cnt == 3'd7);
    assign cmd_ok    = (byte_in == CMD_WRITE) || (byte_in == CMD_READ);
    assign addr_inc  = addr + ADDR_W'(1);
    assign lcl_rdata = rd_byte(lcl_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Unknown commands fall straight into DATA with mode NONE, which
    // swallows the rest of the frame without writes or miso activity.
    always_comb begin
        state_nxt = state;
        if (cs_n_s) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_CMD;
                ST_CMD: begin
                    if (byte_done) begin
                        state_nxt = cmd_ok ? ST_ADDR : ST_DATA;
                    end
                end
                ST_ADDR: begin
                    if (byte_done) begin
                        state_nxt = ST_DATA;
                    end
                end
                ST_DATA: state_nxt = ST_DATA;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d      <= 1'b0;
            mode        <= XF_NONE;
            bit_cnt     <= 3'd0;
            shift_in    <= 7'd0;
            shift_out   <= 8'd0;
            addr        <= '0;
            wr_pend     <= 1'b0;
            wr_byte     <= 8'd0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            spi_wr_stb  <= 1'b0;
            spi_wr_addr <= '0;
        end else begin
            sclk_d     <= sclk_s;
            wr_pend    <= 1'b0;
            spi_wr_stb <= 1'b0;
            miso_oe    <= ~cs_n_s;

            // Deselect drops any partial byte: bit_cnt restarts and
            // wr_pend is only ever raised by a completed byte.
            if (cs_n_s || state == ST_IDLE) begin
                bit_cnt   <= 3'd0;
                shift_out <= 8'd0;
                miso      <= 1'b0;
                if (state == ST_IDLE) begin
                    mode <= XF_NONE;
                end
            end else begin
                if (rise) begin
                    bit_cnt  <= bit_cnt + 3'd1;
                    shift_in <= byte_in[6:0];
                end
                if (byte_done) begin
                    case (state)
                        ST_CMD: begin
                            if (byte_in == CMD_WRITE) begin
                                mode <= XF_WRITE;
                            end else if (byte_in == CMD_READ) begin
                                mode <= XF_READ;
                            end else begin
                                mode <= XF_NONE;
                            end
                        end
                        ST_ADDR: begin
                            addr <= byte_in[ADDR_W-1:0];
                            if (mode == XF_READ) begin
                                shift_out <= rd_byte(byte_in[ADDR_W-1:0]);
                            end
                        end
                        ST_DATA: begin
                            if (mode == XF_WRITE) begin
                                wr_pend <= 1'b1;
                                wr_byte <= byte_in;
                            end else if (mode == XF_READ) begin
                                addr      <= addr_inc;
                                shift_out <= rd_byte(addr_inc);
                            end
                        end
                        default: ;
                    endcase
                end
                if (fall) begin
                    if (state == ST_DATA && mode == XF_READ) begin
                        miso      <= shift_out[7];
                        shift_out <= {shift_out[6:0], 1'b0};
                    end else begin
                        miso <= 1'b0;
                    end
                end
            end

            // A completed write byte commits even if cs_n has just risen.
            if (wr_pend) begin
                addr        <= addr_inc;
                spi_wr_stb  <= ~is_ro(addr);
                spi_wr_addr <= addr;
            end
        end
    end

    // SPI commit is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (lcl_we && !is_ro(lcl_addr)) begin
                mem[lcl_addr] <= lcl_wdata;
            end
            if (wr_pend && !is_ro(addr)) begin
                mem[addr] <= wr_byte;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Self-checking bench for spi_reg_responder with a byte-array model.
// Directed scenarios followed by randomized SPI/local traffic.
module tb_spi_reg_responder;

    localparam int ADDR_W = 6;
    localparam int MEM    = 64;
    localparam int HALF   = 60;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sclk = 1'b0;
    logic              cs_n = 1'b1;
    logic              mosi = 1'b0;
    logic              miso;
    logic              miso_oe;
    logic [ADDR_W-1:0] lcl_addr = '0;
    logic [7:0]        lcl_wdata = 8'h00;
    logic              lcl_we = 1'b0;
    logic [7:0]        lcl_rdata;
    logic              spi_wr_stb;
    logic [ADDR_W-1:0] spi_wr_addr;

    spi_reg_responder #(
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .lcl_addr    (lcl_addr),
        .lcl_wdata   (lcl_wdata),
        .lcl_we      (lcl_we),
        .lcl_rdata   (lcl_rdata),
        .spi_wr_stb  (spi_wr_stb),
        .spi_wr_addr (spi_wr_addr)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  ref_mem [MEM];
    int          stb_q [$];
    logic [7:0]  tx_q [$];
    logic [7:0]  rx_q [$];
    logic        coll_go = 1'b0;
    logic        seen = 1'b0;

    always @(posedge clk) begin
        if (spi_wr_stb === 1'b1) begin
            stb_q.push_back(int'(spi_wr_addr));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit ro(input int a);
`ifdef READONLY_ID_EN
        return a < 4;
`else
        return (a < 0);
`endif
    endfunction

    function automatic logic [7:0] id_val(input int a);
        case (a)
            0:       return 8'hAD;
            1:       return 8'h1D;
            2:       return 8'hF2;
            default: return 8'h01;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MEM; i++) begin
            ref_mem[i] = ro(i) ? id_val(i) : 8'h00;
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = tx[7-i];
            #HALF;
            sclk = 1'b1;
            rx[7-i] = miso;
            #HALF;
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        #100;
    endtask

    task automatic cs_high();
        #100;
        cs_n = 1'b1;
        mosi = 1'b0;
        #200;
    endtask

    task automatic run_txn(input logic [7:0] cmd, input int addr);
        logic [7:0] r;
        rx_q.delete();
        cs_low();
        spi_bits(cmd, 8, r);
        spi_bits(8'(addr), 8, r);
        foreach (tx_q[i]) begin
            spi_bits(tx_q[i], 8, r);
            rx_q.push_back(r);
        end
        cs_high();
    endtask

    task automatic lcl_check(input int a);
        lcl_addr = ADDR_W'(a);
        #10;
        chk($sformatf("lcl_rd[%0h]", a), lcl_rdata, ref_mem[a]);
    endtask

    task automatic lcl_write(input int a, input logic [7:0] d);
        lcl_addr  = ADDR_W'(a);
        lcl_wdata = d;
        lcl_we    = 1'b1;
        #10;
        lcl_we    = 1'b0;
        if (!ro(a)) ref_mem[a] = d;
    endtask

    task automatic do_write(input int addr);
        int exp [$];
        int a;
        stb_q.delete();
        run_txn(8'h0A, addr);
        foreach (tx_q[i]) begin
            a = (addr + i) % MEM;
            if (!ro(a)) begin
                ref_mem[a] = tx_q[i];
                exp.push_back(a);
            end
        end
        chk("wr_stb_cnt", stb_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < stb_q.size(); i++) begin
            chk("wr_stb_addr", stb_q[i], exp[i]);
        end
        foreach (tx_q[i]) lcl_check((addr + i) % MEM);
    endtask

    task automatic do_read(input int addr, input int n);
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
        run_txn(8'h0B, addr);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("rd[%0h]", (addr + i) % MEM), rx_q[i],
                ref_mem[(addr + i) % MEM]);
        end
    endtask

    task automatic do_bogus(input logic [7:0] cmd, input int addr,
                            input int n);
        int a;
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
        stb_q.delete();
        run_txn(cmd, addr);
        foreach (rx_q[i]) chk("bogus_miso", rx_q[i], 8'h00);
        chk("bogus_stb", stb_q.size(), 0);
        a = (addr + 1) % MEM;
        lcl_check(a);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] r;
        int         sel;
        int         a;
        int         n;
        logic [7:0] c;

        model_reset();
        #20;
        chk("rst_miso", miso, 1'b0);
        chk("rst_oe", miso_oe, 1'b0);
        chk("rst_stb", spi_wr_stb, 1'b0);
        chk("rst_stb_addr", spi_wr_addr, 0);
        chk("rst_rdata0", lcl_rdata, ref_mem[0]);
        rst_n = 1'b1;
        #40;
        lcl_check(3);

        tx_q = '{8'h5A};
        do_write(8'h10);

        tx_q = '{8'h11, 8'h22};
        do_write(8'h3F);

        do_read(8'h00, 2);
`ifdef READONLY_ID_EN
        chk("id_byte0", rx_q[0], 8'hAD);
        chk("id_byte1", rx_q[1], 8'h1D);
`endif

        stb_q.delete();
        cs_low();
        spi_bits(8'h0A, 8, r);
        spi_bits(8'h20, 8, r);
        spi_bits(8'hFF, 4, r);
        cs_high();
        chk("partial_stb", stb_q.size(), 0);
        lcl_check(8'h20);
        tx_q = '{8'h99};
        do_write(8'h20);

        stb_q.delete();
        coll_go = 1'b0;
        seen = 1'b0;
        fork
            begin
                cs_low();
                spi_bits(8'h0A, 8, r);
                spi_bits(8'h08, 8, r);
                coll_go = 1'b1;
                spi_bits(8'h33, 8, r);
                cs_high();
            end
            begin
                wait (coll_go);
                lcl_addr  = ADDR_W'(8);
                lcl_wdata = 8'h44;
                lcl_we    = 1'b1;
                for (int k = 0; k < 400 && !seen; k++) begin
                    @(negedge clk);
                    if (spi_wr_stb === 1'b1) seen = 1'b1;
                end
                lcl_we = 1'b0;
            end
        join
        ref_mem[8] = 8'h33;
        chk("coll_stb_seen", seen, 1'b1);
        chk("coll_stb_cnt", stb_q.size(), 1);
        lcl_check(8);

        tx_q = '{8'h77};
        do_write(8'h10);
        cs_low();
        spi_bits(8'h0B, 8, r);
        spi_bits(8'h10, 8, r);
        spi_bits(8'h00, 4, r);
        chk("mid_oe_active", miso_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_oe", miso_oe, 1'b0);
        chk("mid_rst_miso", miso, 1'b0);
        #9;
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        #40;
        rst_n = 1'b1;
        model_reset();
        stb_q.delete();
        #40;
        do_read(8'h10, 1);
        lcl_check(0);

        for (int it = 0; it < 30; it++) begin
            sel = $urandom_range(0, 9);
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 63)
                                             : $urandom_range(0, MEM - 1);
            n = $urandom_range(1, 3);
            if (sel <= 3) begin
                tx_q.delete();
                for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
                do_write(a);
            end else if (sel <= 6) begin
                do_read(a, n);
            end else if (sel == 7) begin
                do begin
                    c = 8'($urandom);
                end while (c == 8'h0A || c == 8'h0B);
                do_bogus(c, a, n);
            end else begin
                lcl_write(a, 8'($urandom));
                lcl_check(a);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_responder.md
SPI_REG_RESPONDER -- requirements
Module: spi_reg_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, register-file address width (64 bytes).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on SPI inputs (legal 2..3).
REQ-003 SHALL have ports: clk  in  1  system clock; rising edge only.
REQ-004 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: sclk  in  1; cs_n  in  1; mosi  in  1  (async SPI mode 0 pins).
REQ-006 SHALL have ports: miso  out  1; miso_oe  out  1  (drive enable, high only while cs_n low).
REQ-007 SHALL have ports: lcl_addr  in  ADDR_W; lcl_wdata  in  8; lcl_we  in  1; lcl_rdata  out  8  (SoC-side access).
REQ-008 SHALL have ports: spi_wr_stb  out  1; spi_wr_addr  out  ADDR_W  (one-cycle pulse per SPI-written byte).
REQ-009 SHALL require clk >= 8x sclk frequency.

Function
REQ-010 SHALL synchronize sclk, cs_n, mosi through SYNC_STAGES flops, then detect sclk rise/fall from synchronized samples.
REQ-011 SHALL act as SPI mode-0 responder, MSB first: sample mosi on sclk rise, change miso on sclk fall.
REQ-012 SHALL implement FSM IDLE -> CMD -> ADDR -> DATA; cs_n low enters CMD, cs_n high from any state returns to IDLE within 1 clk of synchronized edge.
REQ-013 SHALL accept commands 0x0A (write) and 0x0B (read); any other command enters DATA-ignore: no writes, miso = 0.
REQ-014 SHALL, on 8th rise of ADDR byte, latch address; for read, load shift-out with mem[addr] so bit7 appears on next sclk fall.
REQ-015 SHALL, in read, load next byte mem[addr+1] on 8th rise of each data byte (burst).
REQ-016 SHALL, in write, commit byte to mem[addr] 1 clk after 8th rise, pulse spi_wr_stb with spi_wr_addr, then increment addr.
REQ-017 SHALL wrap address 2^ADDR_W-1 -> 0 in bursts.
REQ-018 SHALL discard a partial byte when cs_n rises mid-byte; no write, no strobe.
REQ-019 SHALL give lcl_rdata = mem[lcl_addr] combinationally; lcl_we writes on clk rise.
REQ-020 SHALL, when SPI commit and lcl_we target the same address in the same cycle, keep the SPI value.
REQ-021 SHALL hold miso = 0 and miso_oe = 0 while cs_n high.

Reset
REQ-022 SHALL, on rst_n low, asynchronously force FSM IDLE, counters 0, miso 0, miso_oe 0, spi_wr_stb 0, spi_wr_addr 0, synchronizers to idle (sclk 0, cs_n 1).
REQ-023 SHALL reset all register bytes to 0x00 except ID bytes per REQ-025.
REQ-024 SHALL abort an in-progress transfer on reset; first transaction after release needs a fresh cs_n fall.

Configuration
REQ-025 SHALL, with READONLY_ID_EN defined, fix bytes 0x00..0x03 to 0xAD, 0x1D, 0xF2, 0x01: SPI and local writes ignored, no spi_wr_stb for them, still readable.
REQ-026 SHALL, without READONLY_ID_EN, treat 0x00..0x03 as ordinary R/W bytes resetting to 0x00.

Structure
REQ-027 SHALL place command codes (0x0A, 0x0B), FSM state enum and ID byte constants in shared package spi_reg_pkg.
REQ-028 SHALL instantiate sub-module sync_bit (parameterized-depth flop chain, async active-low reset, reset value parameter) per SPI input.

Verification
REQ-029 SHALL cover: cs_n low, send 0x0A,0x10,0x5A -> mem[0x10]=0x5A, spi_wr_stb once with addr 0x10.
REQ-030 SHALL cover: burst write 0x0A,0x3F,0x11,0x22 -> mem[0x3F]=0x11, mem[0x00]=0x22 (without READONLY_ID_EN); with it, mem[0x00] stays 0xAD and one strobe.
REQ-031 SHALL cover: read 0x0B,0x00,2 dummy bytes with READONLY_ID_EN -> miso returns 0xAD then 0x1D.
REQ-032 SHALL cover: 0x0A,0x20, 4 bits then cs_n high -> mem[0x20] unchanged, no strobe; next transaction works normally.
REQ-033 SHALL cover: SPI commit 0x33 and lcl_we 0x44 to 0x08 in same clk -> lcl_rdata 0x33.
REQ-034 SHALL cover: rst_n low mid-read -> miso_oe 0 immediately, subsequent 0x0B,0x10 read returns 0x00.
